kalman_frame_tx: RTL

//   Reads the gyro Kalman filter outputs (state estimate x, covariance p) on a

---
 rtl/kalman_frame_tx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/kalman_frame_tx.sv
// Snapshots the Kalman filter state/covariance on a trigger and streams it as a
// checksummed byte frame (header, x, optional p, seq, chk) over valid/ready.
module kalman_frame_tx #(
    parameter logic [7:0] HDR0 = 8'hC0,
    parameter logic [7:0] HDR1 = 8'hC0,
    parameter bit         P_EN = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_trig,
    input  logic signed [31:0] i_x,
    input  logic signed [31:0] i_p,
    output logic        [7:0]  o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_busy,
    output logic        [15:0] o_drop_cnt
);

    localparam int         FRAME_LEN = P_EN ? 12 : 8;
    localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t             r_state, w_state_nxt;
    logic        [3:0]  r_idx, w_idx_nxt;
    logic signed [31:0] r_x, r_p;
    logic        [7:0]  r_seq, r_chk;
    logic        [15:0] r_drop_cnt;
    logic               w_capture, w_drop, w_seq_inc;
    logic        [7:0]  w_byte, w_chk_nxt;

    function automatic logic [7:0] byte_sum(input logic [31:0] v);
        return v[31:24] + v[23:16] + v[15:8] + v[7:0];
    endfunction

    // Checksum is built from the live inputs so it is ready with the snapshot.
    always_comb begin
        w_chk_nxt = byte_sum(i_x) + r_seq;
        if (P_EN)
            w_chk_nxt = w_chk_nxt + byte_sum(i_p);
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            4'd0:    w_byte = HDR0;
            4'd1:    w_byte = HDR1;
            4'd2:    w_byte = r_x[31:24];
            4'd3:    w_byte = r_x[23:16];
            4'd4:    w_byte = r_x[15:8];
            4'd5:    w_byte = r_x[7:0];
            4'd6:    w_byte = P_EN ? r_p[31:24] : r_seq;
            4'd7:    w_byte = P_EN ? r_p[23:16] : r_chk;
            4'd8:    w_byte = r_p[15:8];
            4'd9:    w_byte = r_p[7:0];
            4'd10:   w_byte = r_seq;
            4'd11:   w_byte = r_chk;
            default: w_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_capture   = 1'b0;
        w_drop      = 1'b0;
        w_seq_inc   = 1'b0;
        o_valid     = 1'b0;
        o_busy      = 1'b0;
        o_data      = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (i_trig) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                o_valid = 1'b1;
                o_busy  = 1'b1;
                o_data  = w_byte;
                w_drop  = i_trig;
                if (i_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt   = 4'd0;
                        w_seq_inc   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= 4'd0;
            r_x        <= '0;
            r_p        <= '0;
            r_seq      <= 8'h00;
            r_chk      <= 8'h00;
            r_drop_cnt <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_capture) begin
                r_x   <= i_x;
                r_p   <= i_p;
                r_chk <= w_chk_nxt;
            end
            if (w_seq_inc)
                r_seq <= r_seq + 8'd1;
            if (w_drop && (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign o_drop_cnt = r_drop_cnt;

endmodule
